mealy5_conformance_checker: RTL and testbench

//  Active test partner for the 5-state Mealy machine: drives its load/reset, stimulus and step

---
 rtl/mealy5_pkg.sv | 28 ++
 rtl/mealy5_golden_rom.sv | 14 +
 rtl/mealy5_conformance_checker.sv | 115 +++++++++++
 tb/tb_mealy5_conformance_checker.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mealy5_pkg.sv
// mealy5_pkg: shared sizes, golden transition table and checker FSM encoding
package mealy5_pkg;
    localparam int N_STATES = 5;
    localparam int SW_W = 2;
    localparam int ST_W = 3;
    localparam int N_IN = 2 ** SW_W;
    localparam int KIND_LOAD = 2;
    localparam int KIND_NEXT = 1;
    localparam int KIND_OUT = 0;
    typedef logic [2:0] chk_state_t;
    localparam chk_state_t IDLE = 3'd0;
    localparam chk_state_t LOAD = 3'd1;
    localparam chk_state_t SETTLE = 3'd2;
    localparam chk_state_t APPLY = 3'd3;
    localparam chk_state_t CHECK = 3'd4;
    localparam chk_state_t DONE = 3'd5;
    localparam logic [ST_W-1:0] GOLD_NEXT [N_STATES][N_IN] = '{
        '{3'd1, 3'd4, 3'd1, 3'd2},
        '{3'd4, 3'd2, 3'd4, 3'd0},
        '{3'd4, 3'd2, 3'd3, 3'd3},
        '{3'd2, 3'd2, 3'd1, 3'd0},
        '{3'd1, 3'd3, 3'd0, 3'd4}
    };
    // bit i of each entry is the output for input i
    localparam logic [N_IN-1:0] GOLD_OUT [N_STATES] = '{
        4'b1010, 4'b0010, 4'b0011, 4'b0011, 4'b1011
    };
endpackage

// File: rtl/mealy5_golden_rom.sv
// mealy5_golden_rom: combinational (state, input) -> expected {next, out} lookup
module mealy5_golden_rom
    import mealy5_pkg::*;
(
    input  logic [ST_W-1:0] s,
    input  logic [SW_W-1:0] i,
    output logic [ST_W-1:0] gold_next,
    output logic            gold_out
);
    always_comb begin
        gold_next = (s < ST_W'(N_STATES)) ? GOLD_NEXT[s][i] : '0;
        gold_out = (s < ST_W'(N_STATES)) ? GOLD_OUT[s][i] : 1'b0;
    end
endmodule

// File: rtl/mealy5_conformance_checker.sv
// mealy5_conformance_checker: walks all 20 (state,input) vectors on the Mealy DUT
// and compares loaded state, next state and output against the golden table.
module mealy5_conformance_checker
    import mealy5_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            dut_rst,
    output logic [ST_W-1:0] dut_state_in,
    output logic [SW_W-1:0] dut_sw,
    output logic            dut_ctrl,
    input  logic [ST_W-1:0] dut_state,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [4:0]      err_count,
    output logic            err_valid,
    output logic [ST_W-1:0] err_state,
    output logic [SW_W-1:0] err_input,
    output logic [2:0]      err_kind,
    output logic [ST_W-1:0] first_err_state,
    output logic [SW_W-1:0] first_err_input,
    output logic [2:0]      first_err_kind
);
    chk_state_t state, nxt;
    logic [ST_W-1:0] s, s_nx, gold_next;
    logic [SW_W-1:0] i, i_nx;
    logic gold_out, load_err, last, i_wrap;
    logic [2:0] kind;

    mealy5_golden_rom u_rom (
        .s        (s),
        .i        (i),
        .gold_next(gold_next),
        .gold_out (gold_out)
    );

    always_comb begin
        i_wrap = i == SW_W'(N_IN - 1);
        last = i_wrap && s == ST_W'(N_STATES - 1);
        nxt = state == IDLE   ? (start ? LOAD : IDLE) :
              state == LOAD   ? SETTLE :
              state == SETTLE ? APPLY :
              state == APPLY  ? CHECK :
              state == CHECK  ? (last ? DONE : LOAD) : IDLE;
        // vector counters are pre-computed so the DUT-facing flops carry the upcoming vector
        i_nx = state == IDLE ? '0 : state == CHECK ? i + 1'b1 : i;
        s_nx = state == IDLE ? '0 : (state == CHECK && i_wrap) ? (last ? '0 : s + 1'b1) : s;
        kind = {load_err, dut_state != gold_next, dut_out != gold_out};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            s <= '0;
            i <= '0;
            load_err <= 1'b0;
            dut_rst <= 1'b0;
            dut_state_in <= '0;
            dut_sw <= '0;
            dut_ctrl <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            err_count <= '0;
            err_valid <= 1'b0;
            err_state <= '0;
            err_input <= '0;
            err_kind <= '0;
            first_err_state <= '0;
            first_err_input <= '0;
            first_err_kind <= '0;
        end else begin
            state <= nxt;
            s <= s_nx;
            i <= i_nx;
            dut_rst <= nxt == LOAD;
            dut_ctrl <= nxt == APPLY;
            dut_state_in <= s_nx;
            dut_sw <= i_nx;
            err_valid <= 1'b0;
            if (state == IDLE && start) begin
                busy <= 1'b1;
                done <= 1'b0;
                pass <= 1'b0;
                err_count <= '0;
                first_err_state <= '0;
                first_err_input <= '0;
                first_err_kind <= '0;
            end
            if (state == SETTLE)
                load_err <= dut_state != s;
            if (state == CHECK && |kind) begin
                err_valid <= 1'b1;
                err_count <= err_count + 5'd1;
                err_state <= s;
                err_input <= i;
                err_kind <= kind;
                if (err_count == '0) begin
                    first_err_state <= s;
                    first_err_input <= i;
                    first_err_kind <= kind;
                end
            end
            if (state == CHECK && last)
                busy <= 1'b0;
            if (state == DONE) begin
                done <= 1'b1;
                pass <= err_count == '0;
            end
        end
    end
endmodule

// File: tb/tb_mealy5_conformance_checker.sv
// tb_mealy5_conformance_checker: drives the checker against a configurable (optionally faulty)
// Mealy model and predicts the reported failures vector by vector from the golden table.
module tb_mealy5_conformance_checker;
    logic clk = 0, reset = 1, start = 0;
    logic dut_rst, dut_ctrl, dut_out, busy, done, pass, err_valid;
    logic [2:0] dut_state_in, dut_state, err_state, err_kind, first_err_state, first_err_kind;
    logic [1:0] dut_sw, err_input, first_err_input;
    logic [4:0] err_count;
    int checks = 0, errors = 0;
    int gn [5][4] = '{'{1,4,1,2}, '{4,2,4,0}, '{4,2,3,3}, '{2,2,1,0}, '{1,3,0,4}};
    int go [5][4] = '{'{0,1,0,1}, '{0,1,0,0}, '{1,1,0,0}, '{1,1,0,0}, '{1,1,0,1}};
    int dnx [5][4];
    int dox [5][4];
    bit load0 = 0;
    logic [2:0] m_state = 0;
    logic m_out = 0;
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int ctrl_cnt = 0, proto_bad = 0;
    logic [1:0] rst_h = 0, sw_ld = 0;
    logic ctrl_h = 0;

    always #5 clk = ~clk;

    mealy5_conformance_checker dut (
        .clk(clk), .reset(reset), .start(start),
        .dut_rst(dut_rst), .dut_state_in(dut_state_in), .dut_sw(dut_sw), .dut_ctrl(dut_ctrl),
        .dut_state(dut_state), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .err_valid(err_valid), .err_state(err_state), .err_input(err_input), .err_kind(err_kind),
        .first_err_state(first_err_state), .first_err_input(first_err_input),
        .first_err_kind(first_err_kind)
    );

    // Mealy machine under test: synchronous load on rst, registered step on ctrl
    always @(posedge clk) begin
        if (dut_rst) begin
            m_state <= load0 ? 3'd0 : dut_state_in;
            m_out <= 1'b0;
        end else if (dut_ctrl && m_state < 5) begin
            m_state <= 3'(dnx[m_state][dut_sw]);
            m_out <= 1'(dox[m_state][dut_sw]);
        end
    end
    assign dut_state = m_state;
    assign dut_out = m_out;

    always @(negedge clk) begin
        if (err_valid) got_q.push_back({err_state, err_input, err_kind});
        if (dut_ctrl) begin
            ctrl_cnt++;
            if (!(rst_h[1] && !rst_h[0] && !ctrl_h) || dut_sw !== sw_ld) proto_bad++;
        end
        if (ctrl_h && dut_sw !== sw_ld) proto_bad++;
        if (dut_rst) sw_ld = dut_sw;
        rst_h = {rst_h[0], dut_rst};
        ctrl_h = dut_ctrl;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_faults(input bit ld0, input int n_rand);
        load0 = ld0;
        for (int s = 0; s < 5; s++)
            for (int i = 0; i < 4; i++) begin
                dnx[s][i] = gn[s][i];
                dox[s][i] = go[s][i];
            end
        for (int k = 0; k < n_rand; k++) begin
            int s = $urandom_range(0, 4), i = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) dnx[s][i] = $urandom_range(0, 7);
            else dox[s][i] = 1 - dox[s][i];
        end
    endtask

    // expected failure list: what the model does versus what the golden table demands
    task automatic predict();
        exp_q.delete();
        for (int s = 0; s < 5; s++)
            for (int i = 0; i < 4; i++) begin
                int ld = load0 ? 0 : s;
                logic [2:0] k = {ld != s, dnx[ld][i] != gn[s][i], dox[ld][i] != go[s][i]};
                if (k != 0) exp_q.push_back({3'(s), 2'(i), k});
            end
    endtask

    task automatic clear_mon();
        got_q.delete();
        ctrl_cnt = 0;
        proto_bad = 0;
    endtask

    task automatic kick();
        clear_mon();
        @(negedge clk) start = 1;
        @(posedge clk);
        #1 start = 0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(output int n, input int rst_at, input bit extra);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (extra && (n == 10 || n == 50)) start = 1;
            if (extra && (n == 11 || n == 51)) start = 0;
            if (n == rst_at) return;
            if (done) break;
        end
    endtask

    task automatic check_results(input string nm);
        chk({nm, "_done"}, done, 1);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_pass"}, pass, exp_q.size() == 0);
        chk({nm, "_err_count"}, err_count, exp_q.size());
        chk({nm, "_first_err"}, {first_err_state, first_err_input, first_err_kind},
            exp_q.size() > 0 ? exp_q[0] : 8'h0);
        chk({nm, "_pulses"}, got_q.size(), exp_q.size());
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            chk({nm, "_pulse"}, got_q[k], exp_q[k]);
        chk({nm, "_ctrl_cnt"}, ctrl_cnt, 20);
        chk({nm, "_protocol"}, proto_bad, 0);
        chk({nm, "_dut_rst_idle"}, {dut_rst, dut_ctrl}, 0);
    endtask

    initial begin
        int n;
        set_faults(0, 0);
        #1;
        chk("reset_outs", {dut_rst, dut_ctrl, busy, done, pass, err_valid, err_count}, 0);
        chk("reset_first", {first_err_state, first_err_input, first_err_kind}, 0);
        @(negedge clk) reset = 0;
        @(negedge clk);
        chk("idle_outs", {dut_rst, dut_ctrl, busy, done}, 0);

        predict();
        kick();
        wait_done(n, -1, 0);
        chk("clean_latency", n, 81);
        check_results("clean");

        set_faults(0, 0);
        dox[0][3] = 0; dnx[1][0] = 3; dox[1][0] = 1; dnx[3][1] = 5;
        dox[4][0] = 0; dnx[4][3] = 7; dox[4][3] = 0;
        predict();
        kick();
        wait_done(n, -1, 0);
        chk("five_latency", n, 81);
        check_results("five");

        set_faults(1, 0);
        predict();
        kick();
        wait_done(n, -1, 0);
        chk("load0_latency", n, 81);
        check_results("load0");

        set_faults(0, 3);
        predict();
        kick();
        wait_done(n, -1, 1);
        chk("ignore_start_latency", n, 81);
        check_results("ignore_start");
        repeat (5) @(posedge clk);
        #1 chk("single_done", {done, busy}, 2'b10);

        set_faults(0, 4);
        predict();
        kick();
        wait_done(n, 30, 0);
        reset = 1;
        #1;
        chk("abort_outs", {dut_rst, dut_ctrl, busy, done, pass, err_valid, err_count}, 0);
        chk("abort_first", {first_err_state, first_err_input, first_err_kind}, 0);
        @(negedge clk) reset = 0;
        kick();
        wait_done(n, -1, 0);
        chk("after_abort_latency", n, 81);
        check_results("after_abort");

        for (int r = 0; r < 3; r++) begin
            set_faults($urandom_range(0, 3) == 0, $urandom_range(0, 6));
            predict();
            kick();
            wait_done(n, -1, 0);
            chk("rand_latency", n, 81);
            check_results("rand");
        end

        set_faults(0, 2);
        predict();
        @(negedge clk) start = 1;
        wait_done(n, -1, 0);
        chk("held_first_done", done, 1);
        clear_mon();
        @(posedge clk);
        #1 chk("held_restart", {done, busy}, 2'b01);
        start = 0;
        wait_done(n, -1, 0);
        chk("held_latency", n, 81);
        check_results("held");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
